// File: rtl/aes_pkg.sv
// ============================================================================
// aes_pkg : shared types and frame geometry for the AES decrypt loader
// Rev 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;
    localparam int AES_FRAME_BYTES = 32;

    typedef enum logic [1:0] {
        S_LOAD_KEY  = 2'd0,
        S_LOAD_DATA = 2'd1,
        S_FIRE      = 2'd2,
        S_WAIT_DONE = 2'd3
    } aes_ld_state_t;

    // Most significant byte arrives first, so new bytes enter at the bottom.
    function automatic logic [127:0] shift_in_byte(input logic [127:0] cur,
                                                   input logic [7:0]   b);
        return {cur[119:0], b};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_idle_timer.sv
// ============================================================================
// aes_idle_timer : inter-byte idle counter, expires after LIMIT idle cycles
// Rev 1.0
// ============================================================================
`default_nettype none

module aes_idle_timer #(
    parameter int LIMIT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [15:0] count;

    // Fires on the idle cycle whose increment would reach LIMIT.
    assign expire = en && (count == 16'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 16'd0;
        end else if (clr || expire) begin
            count <= 16'd0;
        end else if (en) begin
            count <= count + 16'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/aes_dec_loader.sv
// ============================================================================
// aes_dec_loader : byte-stream frame loader feeding the AES-128 decrypt core
// Optional inter-byte timeout built when AES_LOADER_TIMEOUT_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module aes_dec_loader
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         aes_valid,
    output logic [127:0] aes_key,
    output logic [127:0] aes_datain,
    input  logic         aes_done,
    output logic         busy,
    output logic         err_timeout
);

    localparam logic [4:0] LAST_KEY_BYTE   = 5'(AES_BLOCK_BYTES - 1);
    localparam logic [4:0] LAST_FRAME_BYTE = 5'(AES_FRAME_BYTES - 1);

    aes_ld_state_t state;
    logic [4:0]    byte_cnt;
    logic          xfer;
    logic          expire;

    assign in_ready = (state == S_LOAD_KEY) || (state == S_LOAD_DATA);
    assign xfer     = in_valid && in_ready;

`ifdef AES_LOADER_TIMEOUT_EN
    logic timer_clr;
    logic timer_en;

    assign timer_clr = xfer || (byte_cnt == 5'd0);
    assign timer_en  = in_ready && (byte_cnt != 5'd0) && !xfer;

    aes_idle_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .en     (timer_en),
        .expire (expire)
    );
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^16'(TIMEOUT_CYCLES);
    assign expire             = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_LOAD_KEY;
            byte_cnt    <= 5'd0;
            aes_key     <= 128'd0;
            aes_datain  <= 128'd0;
            aes_valid   <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            aes_valid   <= 1'b0;
            err_timeout <= expire;
            case (state)
                S_LOAD_KEY: begin
                    if (xfer) begin
                        aes_key  <= shift_in_byte(aes_key, in_data);
                        byte_cnt <= byte_cnt + 5'd1;
                        if (byte_cnt == LAST_KEY_BYTE) begin
                            state <= S_LOAD_DATA;
                        end
                    end else if (expire) begin
                        byte_cnt <= 5'd0;
                    end
                end
                S_LOAD_DATA: begin
                    if (xfer) begin
                        aes_datain <= shift_in_byte(aes_datain, in_data);
                        byte_cnt   <= byte_cnt + 5'd1;
                        if (byte_cnt == LAST_FRAME_BYTE) begin
                            state     <= S_FIRE;
                            aes_valid <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end else if (expire) begin
                        byte_cnt <= 5'd0;
                        state    <= S_LOAD_KEY;
                    end
                end
                S_FIRE: begin
                    state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (aes_done) begin
                        busy  <= 1'b0;
                        state <= S_LOAD_KEY;
                    end
                end
                default: begin
                    state <= S_LOAD_KEY;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_dec_loader.sv
// ============================================================================
// tb_aes_dec_loader : directed vector bench for aes_dec_loader
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_aes_dec_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         aes_valid;
    logic [127:0] aes_key;
    logic [127:0] aes_datain;
    logic         aes_done;
    logic         busy;
    logic         err_timeout;

    int total = 0;
    int bad   = 0;
    int vpulses = 0;
    int epulses = 0;
    int exp_v   = 0;
    logic [127:0] cap_key  = '0;
    logic [127:0] cap_data = '0;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        int           max_gap;
        logic [127:0] exp_key;
        logic [127:0] exp_data;
    } vec_t;

    vec_t vecs[3];

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ALT_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ALT_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_dec_loader #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .aes_valid   (aes_valid),
        .aes_key     (aes_key),
        .aes_datain  (aes_datain),
        .aes_done    (aes_done),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (aes_valid) begin
            vpulses++;
            cap_key  = aes_key;
            cap_data = aes_datain;
        end
        if (err_timeout) epulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL ready_wait: got in_ready=0 after %0d cycles want 1", n);
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_range(input logic [127:0] k, input logic [127:0] c,
                              input int lo, input int hi, input int max_gap);
        logic [255:0] f;
        f = {k, c};
        for (int i = lo; i <= hi; i++) begin
            send_byte(f[255-8*i -: 8], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
        end
    endtask

    // Called right after the last byte's accepting edge (start pulse cycle).
    task automatic finish_frame(input string nm, input logic [127:0] ek,
                                input logic [127:0] ed, input bit done_in_fire);
        chk({nm, "_valid_hi"}, 128'(aes_valid), 128'd1);
        chk({nm, "_busy_hi"},  128'(busy),      128'd1);
        chk({nm, "_ready_lo"}, 128'(in_ready),  128'd0);
        exp_v++;
        if (done_in_fire) aes_done = 1'b1;
        tick();
        aes_done = 1'b0;
        chk({nm, "_valid_one_cycle"}, 128'(aes_valid), 128'd0);
        chk({nm, "_busy_wait"},       128'(busy),      128'd1);
        chk({nm, "_pulse_count"},     128'(vpulses),   128'(exp_v));
        chk({nm, "_key"},             cap_key,         ek);
        chk({nm, "_data"},            cap_data,        ed);
        repeat (2) tick();
        chk({nm, "_key_stable"},  aes_key,    ek);
        chk({nm, "_data_stable"}, aes_datain, ed);
        aes_done = 1'b1;
        tick();
        aes_done = 1'b0;
        chk({nm, "_busy_clr"},  128'(busy),     128'd0);
        chk({nm, "_ready_ret"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        vecs[0] = '{FIPS_KEY, FIPS_CT, 0, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{ALT_KEY,  ALT_CT,  2, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{FIPS_KEY, FIPS_CT, 3, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};

        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; aes_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 128'(in_ready),    128'd1);
        chk("rst_valid", 128'(aes_valid),   128'd0);
        chk("rst_busy",  128'(busy),        128'd0);
        chk("rst_err",   128'(err_timeout), 128'd0);
        chk("rst_key",   aes_key,           128'd0);
        chk("rst_data",  aes_datain,        128'd0);
        rst = 1'b1;
        tick();

        // FIPS-197 vector, alternate vector gapped, FIPS gapped
        for (int v = 0; v < 3; v++) begin
            send_range(vecs[v].key, vecs[v].ct, 0, 31, vecs[v].max_gap);
            finish_frame($sformatf("vec%0d", v), vecs[v].exp_key, vecs[v].exp_data, 1'b0);
        end

        // Backpressure: second frame offered while the core is busy
        send_range(FIPS_KEY, FIPS_CT, 0, 31, 0);
        exp_v++;
        chk("bp_first_valid", 128'(aes_valid), 128'd1);
        fork
            send_range(ALT_KEY, ALT_CT, 0, 31, 0);
            begin
                for (int i = 0; i < 4; i++) begin
                    tick();
                    chk("bp_ready_lo", 128'(in_ready), 128'd0);
                end
                chk("bp_key_hold", aes_key, FIPS_KEY);
                aes_done = 1'b1;
                chk("bp_ready_lo_done_cycle", 128'(in_ready), 128'd0);
                tick();
                aes_done = 1'b0;
                chk("bp_busy_clr", 128'(busy), 128'd0);
            end
        join
        finish_frame("bp_second", ALT_KEY, ALT_CT, 1'b1);

`ifdef AES_LOADER_TIMEOUT_EN
        // Timeout after 8 idle cycles discards the partial frame
        e0 = epulses;
        send_range(ALT_KEY, ALT_CT, 0, 9, 0);
        repeat (7) tick();
        chk("to_no_early", 128'(err_timeout), 128'd0);
        tick();
        chk("to_fire", 128'(err_timeout), 128'd1);
        tick();
        chk("to_one_cycle", 128'(err_timeout), 128'd0);
        chk("to_pulse_count", 128'(epulses - e0), 128'd1);
        send_range(FIPS_KEY, FIPS_CT, 0, 31, 0);
        finish_frame("to_after", FIPS_KEY, FIPS_CT, 1'b0);

        // Byte arriving on the limit cycle wins over the timeout
        e0 = epulses;
        send_range(ALT_KEY, ALT_CT, 0, 4, 0);
        send_byte(ALT_KEY[127-8*5 -: 8], 7);
        send_range(ALT_KEY, ALT_CT, 6, 31, 0);
        chk("coinc_no_err", 128'(epulses - e0), 128'd0);
        finish_frame("coinc", ALT_KEY, ALT_CT, 1'b0);
`else
        // Without the timer a partial frame just waits
        e0 = epulses;
        send_range(ALT_KEY, ALT_CT, 0, 9, 0);
        repeat (50) tick();
        chk("nto_no_err", 128'(epulses - e0), 128'd0);
        chk("nto_ready",  128'(in_ready),     128'd1);
        send_range(ALT_KEY, ALT_CT, 10, 31, 0);
        finish_frame("nto_resume", ALT_KEY, ALT_CT, 1'b0);
`endif

        // Reset mid-frame after byte 20
        send_range(FIPS_KEY, FIPS_CT, 0, 20, 0);
        rst = 1'b0;
        #1;
        chk("mrst_key",   aes_key,           128'd0);
        chk("mrst_data",  aes_datain,        128'd0);
        chk("mrst_ready", 128'(in_ready),    128'd1);
        chk("mrst_busy",  128'(busy),        128'd0);
        chk("mrst_valid", 128'(aes_valid),   128'd0);
        chk("mrst_err",   128'(err_timeout), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        send_range(ALT_KEY, ALT_CT, 0, 31, 0);
        finish_frame("mrst_new", ALT_KEY, ALT_CT, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_dec_loader.md
# aes_dec_loader

Byte-stream front end for the AES-128 decryption core. It collects a 32-byte frame over a valid/ready byte interface: 16 key bytes, then 16 ciphertext bytes, most significant byte first. It then issues a one-cycle start pulse with the assembled key and ciphertext to the decryption core, and holds off further input until the core reports done. It sits directly upstream of the decryption core, between the host byte link (UART/FIFO side) and the core's `valid`/`datain`/`key` inputs.

## Interface
- `TIMEOUT_CYCLES`, default 1000: inter-byte idle limit in cycles. Legal range 1..65535. Used only when the timeout feature is compiled in.
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  byte available on `in_data`.
- `in_data`  input  8  stream byte.
- `in_ready`  output  1  loader accepts a byte. A byte transfers when `in_valid && in_ready`.
- `aes_valid`  output  1  one-cycle start pulse to the core.
- `aes_key`  output  128  assembled key. Stable from the `aes_valid` cycle until the next frame is loaded.
- `aes_datain`  output  128  assembled ciphertext. Same stability as `aes_key`.
- `aes_done`  input  1  core completion pulse.
- `busy`  output  1  high from `aes_valid` until the cycle `aes_done` is sampled.
- `err_timeout`  output  1  one-cycle pulse when a partial frame is discarded.

## Operation
- States:
  - S_LOAD_KEY: bytes 0..15.
  - S_LOAD_DATA: bytes 16..31.
  - S_FIRE: drives the start pulse.
  - S_WAIT_DONE: waits for the core.
- Byte counter: 5 bits, counts 0..31.
- Each accepted byte shifts in as `{reg[119:0], in_data}`.
  - Byte 0 ends up in `aes_key[127:120]`.
  - Byte 16 ends up in `aes_datain[127:120]`.
- Transitions:
  - S_LOAD_KEY → S_LOAD_DATA when byte 15 is accepted.
  - S_LOAD_DATA → S_FIRE when byte 31 is accepted. The counter wraps to 0.
  - S_FIRE → S_WAIT_DONE unconditionally after one cycle.
  - S_WAIT_DONE → S_LOAD_KEY when `aes_done` is sampled high.
- `in_ready` = 1 only in S_LOAD_KEY and S_LOAD_DATA.
- `aes_valid` = 1 only in S_FIRE.
- `aes_done` is ignored in every state except S_WAIT_DONE.
- The key and data registers are never modified outside the load states, so the core sees stable inputs.
- Reset values:
  - state S_LOAD_KEY, counter 0.
  - `aes_key`, `aes_datain` = 0.
  - `in_ready` = 1 (combinational from state).
  - `aes_valid`, `busy`, `err_timeout` = 0.
- Reset asserted mid-frame or mid-decrypt: everything returns to reset values immediately and any partial frame is lost. The core is reset by its own reset.

## Timing
- Byte 31 accepted at edge N: `aes_valid` is high during cycle N+1 only, and `busy` rises at N+1.
- `aes_done` sampled at edge M: `busy` = 0 and `in_ready` = 1 from M+1.
- Throughput: a new byte is accepted every cycle while `in_valid` is held.
- Minimum frame-to-start latency: 32 cycles of input plus 1 cycle.

## Configuration
- `AES_LOADER_TIMEOUT_EN` defined:
  - A 16-bit idle counter clears on every accepted byte and while the byte counter is 0.
  - It increments each cycle in a load state when the byte counter is non-zero and no byte transfers.
  - When it reaches `TIMEOUT_CYCLES`:
    - the byte counter clears to 0;
    - the state returns to S_LOAD_KEY;
    - `err_timeout` pulses for one cycle;
    - the idle counter clears.
  - If a transfer occurs in the same cycle the limit is reached, the byte is accepted and no timeout fires.
- `AES_LOADER_TIMEOUT_EN` undefined:
  - No counter is built.
  - `err_timeout` is tied to 0.
  - A partial frame waits indefinitely.

## Structure
- Shared package `aes_pkg` holds:
  - the state enum `aes_ld_state_t`;
  - `AES_BLOCK_BYTES` = 16;
  - `AES_FRAME_BYTES` = 32.
- One sub-module, `aes_idle_timer`: the timeout counter with clear/enable/expire signals. It is instantiated only under `AES_LOADER_TIMEOUT_EN`.

## Test plan
- FIPS-197 vector:
  - Stimulus: key bytes 00 01 … 0f, then ciphertext 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a.
  - Response: one `aes_valid` pulse with `aes_key` = 000102…0f and `aes_datain` = 69c4…c55a. With the core attached, `dataout` = 00112233445566778899aabbccddeeff.
- Backpressure:
  - Stimulus: a second frame streamed while `busy`.
  - Response: `in_ready` = 0 until the cycle after `aes_done`, and no bytes are lost.
- Gapped input:
  - Stimulus: `in_valid` toggled randomly.
  - Response: assembled words are identical to the gap-free case.
- Timeout (macro on, `TIMEOUT_CYCLES` = 8):
  - Stimulus: 10 bytes, then idle.
  - Response: `err_timeout` pulses at idle cycle 8, and a following full frame assembles correctly.
- Limit coincidence (macro on):
  - Stimulus: a byte transfers exactly on the cycle the counter reaches 8.
  - Response: the byte is accepted and no `err_timeout` pulse occurs.
- Reset mid-frame:
  - Stimulus: `rst` = 0 after byte 20.
  - Response: all outputs return to reset values, and a new frame starts at byte 0.
